// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: transfer-size encodings,
// FSM state type, parameter defaults and the alignment rule.
package mem_resp_pkg;

  // Default geometry and timing.
  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_READ_LAT    = 2;

  // Transfer-size encodings carried on the size input.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // A request is illegal for the reserved size or when the byte address is
  // not naturally aligned to the transfer size.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_WORD: bad = (lane != 2'b00);
      SZ_HALF: bad = lane[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_byte_lane_unit.sv
// Combinational lane logic for the memory responder: byte enables, write
// data replication onto lanes, zero-extended read-lane extraction and the
// legality check of a captured request.
module byte_lane_unit
  import mem_resp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection out of the stored word.
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  // Decode size and lane into enables, placed write data and read result.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    be          = 4'b0000;
    wdata_lanes = 32'h0;
    rdata       = 32'h0;
    illegal     = is_illegal(size, lane);

    case (size)
      SZ_WORD: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata       = word;
      end
      SZ_HALF: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = {16'h0, half_sel};
      end
      SZ_BYTE: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = {24'h0, byte_sel};
      end
      default: begin
        be          = 4'b0000;
        wdata_lanes = 32'h0;
        rdata       = 32'h0;
      end
    endcase

    // An illegal request touches no bytes and returns zero.
    if (illegal) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/ready handshake. A request is
// captured in IDLE, waits READ_LAT cycles, is performed on the edge leaving
// ACCESS and reported with a one-cycle ready pulse in RESP.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int READ_LAT    = DEFAULT_READ_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic [31:0] datain,
  output logic        busy,
  output logic        ready,
  output logic [31:0] dataout,
  output logic        error
);

  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  // Last value of the wait counter before moving on to ACCESS.
  localparam int LAT_LAST = (READ_LAT > 0) ? READ_LAT - 1 : 0;

  state_t            state;
  logic [3:0]        wait_cnt;

  // Request captured on the accept edge.
  logic              wr_q;
  logic [IDX_W+1:0]  addr_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word;

  logic [3:0]        be;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rdata;
  logic              illegal;
  logic              commit;

  // Address bits above the array size wrap away; they are never looked at.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^address[31:IDX_W+2];

  assign word_idx = addr_q[IDX_W+1:2];
  assign rd_word  = mem[word_idx];

  byte_lane_unit u_lanes (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .wdata       (data_q),
    .word        (rd_word),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata       (rdata),
    .illegal     (illegal)
  );

  // A legal write lands on the edge that moves ACCESS into RESP.
  assign commit = (state == ACCESS) && wr_q && !illegal;

  // Control FSM, request capture and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      error    <= 1'b0;
      dataout  <= 32'h0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= SZ_WORD;
      data_q   <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (req) begin
            wr_q     <= wr;
            addr_q   <= address[IDX_W+1:0];
            size_q   <= size;
            data_q   <= datain;
            busy     <= 1'b1;
            wait_cnt <= 4'd0;
            state    <= (READ_LAT == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'(LAT_LAST)) begin
            state <= ACCESS;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACCESS: begin
          // Read data is sampled here, before any later write can land.
          state   <= RESP;
          ready   <= 1'b1;
          error   <= illegal;
          dataout <= (wr_q || illegal) ? 32'h0 : rdata;
        end
        RESP: begin
          state    <= IDLE;
          wait_cnt <= 4'd0;
          busy     <= 1'b0;
          ready    <= 1'b0;
          error    <= 1'b0;
          dataout  <= 32'h0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte-enabled write into the storage array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive rst_n and an
    // aborted write never reaches commit because the FSM leaves ACCESS.
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the storage size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter READ_LAT, default 2, giving the wait cycles between accept and response (0..15).
REQ-003 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Req  input  1  request strobe, sampled only in IDLE.
REQ-006 Wr  input  1  1 = write, 0 = read; captured with Req.
REQ-007 Address  input  32  byte address; captured with Req.
REQ-008 Size  input  2  00 word, 01 half, 10 byte, 11 reserved; captured with Req.
REQ-009 Datain  input  32  write data, right-aligned for half and byte; captured with Req.
REQ-010 Busy  output  1  high from the accept edge until the Ready cycle ends.
REQ-011 Ready  output  1  one-cycle completion pulse.
REQ-012 Dataout  output  32  read result; valid only while Ready=1.
REQ-013 Error  output  1  high only together with Ready when the captured request was illegal.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, WAIT, ACCESS and RESP.
REQ-015 Transitions SHALL be:
- IDLE->WAIT on Req=1 when READ_LAT>0;
- IDLE->ACCESS on Req=1 when READ_LAT=0;
- WAIT->ACCESS when the wait counter reaches READ_LAT-1;
- ACCESS->RESP unconditionally;
- RESP->IDLE unconditionally.
REQ-016 On accept edge t0 the block SHALL register Wr, Address, Size and Datain; Ready SHALL be 1 exactly in the cycle after edge t0+READ_LAT+1.
REQ-017 While Busy=1, Req SHALL be ignored; a Req held high SHALL be accepted again in the first IDLE cycle after RESP.
REQ-018 Word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-019 Lanes SHALL be little-endian: byte lane = Address[1:0]; half lane = Address[1].
REQ-020 A request SHALL be illegal when any of these holds:
- Size=11;
- Size=01 with Address[0]=1;
- Size=00 with Address[1:0]!=0.
REQ-021 Illegal requests SHALL produce Ready=1, Error=1 and Dataout=0, with no storage change.
REQ-022 A legal write SHALL commit at the edge entering RESP and update only the selected bytes (word: 4, half: 2, byte: 1); all other bytes SHALL be unchanged.
REQ-023 A legal read SHALL return the selected lane zero-extended to 32 bits, or the full word for Size=00.
REQ-024 A read SHALL return data as it was at the ACCESS edge.
REQ-025 Outside RESP, Ready=0, Error=0 and Dataout=0.
REQ-026 Back-to-back requests SHALL be separated by at least one IDLE cycle; throughput SHALL be one transaction per READ_LAT+3 cycles.

Reset
REQ-027 Reset=0 SHALL immediately force state IDLE, wait counter 0, Busy=0, Ready=0, Error=0 and Dataout=0.
REQ-028 Reset asserted before the commit edge of an in-flight transaction SHALL abort it with no storage change and no Ready pulse.
REQ-029 The storage array SHALL NOT be cleared by Reset.
REQ-030 After Reset deasserts, the first Req SHALL be accepted at the next rising edge.

Structure
REQ-031 Shared package mem_resp_pkg SHALL hold:
- the Size encodings (SZ_WORD, SZ_HALF, SZ_BYTE);
- the state enum;
- the DEPTH_WORDS and READ_LAT defaults.
REQ-032 Byte-enable generation, write-data lane placement, read-lane extraction and the legality check SHALL live in one combinational sub-module byte_lane_unit; the FSM, capture registers and array SHALL stay in mem_responder.

Verification
REQ-033 Word write then read, with READ_LAT=2: Wr=1, Address=0x10, Size=00, Datain=0xDEADBEEF, then a read of 0x10 -> Ready in the 4th cycle after each accept, Dataout=0xDEADBEEF, Error=0.
REQ-034 Lane merge: write word 0x11223344 at 0x20; write byte Datain=0xAA at 0x22; write half Datain=0xBEEF at 0x20 -> word read at 0x20 returns 0x11AABEEF; byte read at 0x23 returns 0x00000011.
REQ-035 Misalignment: read Size=00 at 0x21, write Size=01 at 0x23, any Size=11 -> each gives Ready=1, Error=1, Dataout=0; a later word read of 0x20 is unchanged.
REQ-036 Wrap: with DEPTH_WORDS=256, write 0x12345678 at 0x404 -> word read at 0x004 returns 0x12345678.
REQ-037 Reset mid-write: accept a write to 0x30, pull Reset low during WAIT -> no Ready pulse, Busy drops immediately, 0x30 keeps its old value.
REQ-038 Req held high across three transactions with READ_LAT=0 -> accepts every 3 cycles and Ready occurs exactly once per accept.
